rr_arbiter_hold: RTL and testbench
==================================

RR_ARBITER_HOLD -- requirements
Module: rr_arbiter_hold

Interface
REQ-001: Parameter SIZE, default 4, SHALL set the number of requesters (legal range 2..32).
REQ-002: Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of cycles a grant is held (legal range 2..65535; used only with the timeout feature).
REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005: req  input  SIZE  SHALL carry per-requester request levels.
REQ-006: done  input  SIZE  SHALL carry per-requester release pulses.
REQ-007: gnt  output  SIZE  SHALL be the registered one-hot grant (all zeros when no owner).
REQ-008: gnt_id  output  $clog2(SIZE)  SHALL be the binary index of the current owner (0 when no owner).
REQ-009: busy  output  1  SHALL be high while a grant is held.
REQ-010: timeout  output  1  SHALL be a one-cycle pulse on a forced release.

Function
REQ-011: The arbiter SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-012: In IDLE, if any req bit is high at edge N, the arbiter SHALL enter GRANT, and gnt SHALL be one-hot at the winner after edge N (one-cycle latency).
REQ-013: The winner SHALL be the first set req bit at or above index ptr, wrapping from SIZE-1 to 0 (rotating LSB-first priority).
REQ-014: In IDLE with req all zero, the arbiter SHALL remain in IDLE with gnt, gnt_id and busy at 0.
REQ-015: In GRANT, gnt SHALL remain stable until release, regardless of other req activity.
REQ-016: Release SHALL occur when done[owner] is high, or req[owner] is low, at a clock edge.
REQ-017: On release at edge N, gnt SHALL be zero after edge N, and the state SHALL be IDLE.
REQ-018: Gnt SHALL be low for exactly one cycle between consecutive owners.
REQ-019: On release, ptr SHALL become (owner+1) mod SIZE.
REQ-020: A done bit for a non-owner SHALL be ignored.
REQ-021: A done bit asserted in IDLE SHALL be ignored.
REQ-022: With a single persistent requester k, grants to k SHALL repeat with the pattern 1 cycle granted, 1 cycle idle while k also pulses done.
REQ-023: gnt SHALL never have more than one bit set.

Reset
REQ-024: Assertion of rst_n low SHALL immediately clear gnt, gnt_id, busy and timeout, and SHALL set the state to IDLE, ptr to 0 and the hold counter to 0, including mid-grant.
REQ-025: After rst_n deasserts, the first arbitration SHALL favour index 0.

Configuration
REQ-026: Macro RR_ARBITER_HOLD_TIMEOUT_EN, when defined, SHALL include a hold counter that is cleared on entry to GRANT and increments every GRANT cycle.
REQ-027: With RR_ARBITER_HOLD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without a release, the arbiter SHALL force a release on that edge, pulse timeout for one cycle and advance ptr as per REQ-019.
REQ-028: Without RR_ARBITER_HOLD_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied to 0, TIMEOUT_CYCLES SHALL be ignored, and grants SHALL be held indefinitely.

Verification
REQ-029: After reset, req=4'b1010 -> after 1 cycle gnt=4'b0010, gnt_id=1, busy=1.
REQ-030: Owner 1 pulses done while req=4'b1010 is held -> gnt=0 for 1 cycle, then gnt=4'b1000 (ptr=2 skips index 1).
REQ-031: Owner 3 holds the grant while req toggles 4'b1111/4'b1000 -> gnt stays 4'b1000 until done[3], and done[0] pulses are ignored.
REQ-032: rst_n is driven low mid-grant between clock edges -> gnt=0 and busy=0 immediately, and the next req=4'b1111 grants index 0.
REQ-033: With TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and req=4'b0001 held without done -> timeout pulses after 4 GRANT cycles, gnt=0 for 1 cycle, then gnt=4'b0001.
REQ-034: With TIMEOUT_EN undefined and the same stimulus -> gnt=4'b0001 is held for 100 cycles, and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_hold
// Description : Round-robin arbiter that holds each grant until the owner
//               signals done or drops its request. Optional forced release
//               after TIMEOUT_CYCLES when RR_ARBITER_HOLD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_hold #(
    parameter int SIZE           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SIZE-1:0]         req,
    input  logic [SIZE-1:0]         done,
    output logic [SIZE-1:0]         gnt,
    output logic [$clog2(SIZE)-1:0] gnt_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int ID_W = $clog2(SIZE);
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(SIZE - 1);

    if ((SIZE < 2) || (SIZE > 32) || (TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_param
        $error("rr_arbiter_hold: SIZE or TIMEOUT_CYCLES out of legal range");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SIZE-1:0]   r_gnt;
    logic [SIZE-1:0]   w_gnt_nxt;
    logic [ID_W-1:0]   r_gnt_id;
    logic [ID_W-1:0]   w_gnt_id_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              w_timeout_nxt;
    logic              w_timeout_hit;

    logic [SIZE-1:0]   w_req_hi;
    logic [ID_W-1:0]   w_win_hi;
    logic [ID_W-1:0]   w_win_lo;
    logic [ID_W-1:0]   w_winner;
    logic              w_normal_release;
    logic [ID_W-1:0]   w_ptr_inc;

    // Rotating priority: lowest set request at or above ptr, else lowest overall.
    always_comb begin
        w_req_hi = '0;
        w_win_hi = '0;
        w_win_lo = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_req_hi[i] = req[i] && (ID_W'(i) >= r_ptr);
        end
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (w_req_hi[i]) w_win_hi = ID_W'(i);
            if (req[i])      w_win_lo = ID_W'(i);
        end
    end

    assign w_winner         = (|w_req_hi) ? w_win_hi : w_win_lo;
    assign w_normal_release = done[r_gnt_id] || !req[r_gnt_id];
    assign w_ptr_inc        = (r_gnt_id == C_LAST_ID) ? '0 : r_gnt_id + ID_W'(1);

`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    // Counter sits at zero while idle, so each grant starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (r_state == ST_GRANT) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign w_timeout_hit = (r_hold_cnt == C_HOLD_LAST);
    assign timeout       = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_ptr_nxt     = r_ptr;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt           = ST_GRANT;
                    w_gnt_nxt             = '0;
                    w_gnt_nxt[w_winner]   = 1'b1;
                    w_gnt_id_nxt          = w_winner;
                    w_busy_nxt            = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_normal_release || w_timeout_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = w_ptr_inc;
                    w_timeout_nxt = !w_normal_release;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_hold
// Description : Directed self-checking bench for rr_arbiter_hold (SIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    rr_arbiter_hold #(
        .SIZE           (4),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        tick();
        tick();
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b id=%0d busy=%b to=%b required all 0", gnt, gnt_id, busy, timeout);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            errors++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b required 0", gnt, busy);
        end
        done = 4'b1111;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            errors++;
            $display("FAIL done_in_idle: got gnt=%b busy=%b required 0", gnt, busy);
        end
        done = 4'b0000;
    endtask

    task automatic test_basic();
        req = 4'b1010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: got gnt=%b id=%0d busy=%b required 0010/1/1", gnt, gnt_id, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL grant_held: got %b required 0010", gnt);
        end
        done = 4'b0010;
        tick();
        done = 4'b0000;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_gap: got gnt=%b busy=%b required 0000/0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL rotate_to_3: got gnt=%b id=%0d required 1000/3", gnt, gnt_id);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            req  = (i % 2 == 0) ? 4'b1111 : 4'b1000;
            done = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            checks++;
            if (gnt !== 4'b1000) begin
                errors++;
                $display("FAIL hold_owner3 step %0d: got %b required 1000", i, gnt);
            end
        end
        done = 4'b1000;
        req  = 4'b1111;
        tick();
        done = 4'b0000;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL release_owner3: got %b required 0000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_to_0: got gnt=%b id=%0d required 0001/0", gnt, gnt_id);
        end
        done = 4'b0001;
        tick();
        done = 4'b0000;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL release_owner0: got %b required 0000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL rotate_to_1: got gnt=%b id=%0d required 0010/1", gnt, gnt_id);
        end
        // Dropping the owner's request releases it just like done.
        req = 4'b1101;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL req_drop_release: got %b required 0000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL rotate_to_2: got gnt=%b id=%0d required 0100/2", gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1111;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b id=%0d busy=%b required 0000/0/0", gnt, gnt_id, busy);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_ptr0: got gnt=%b id=%0d required 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_back_to_back();
        req  = 4'b0100;
        done = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_release0: got %b required 0000", gnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== ((i % 2 == 0) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL b2b_pattern step %0d: got %b required %b", i, gnt, (i % 2 == 0) ? 4'b0100 : 4'b0000);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got gnt=%b busy=%b required 0000/0", gnt, busy);
        end
    endtask

`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d: got gnt=%b to=%b required 0001/0", i, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got gnt=%b to=%b busy=%b required 0000/1/0", gnt, timeout, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got gnt=%b to=%b required 0001/0", gnt, timeout);
        end
        req = 4'b0000;
        tick();
    endtask
`else
    task automatic test_hold_forever();
        int bad;
        bad = 0;
        req = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_forever: got %0d bad cycles required 0 (last gnt=%b to=%b)", bad, gnt, timeout);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL hold_forever_release: got %b required 0000", gnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
